// File: rtl/alu_mc_pkg.sv
// ---------------------------------------------------------------------------
// alu_mc_pkg
// Shared definitions for the multi-cycle EXE-stage ALU:
//   ALU_WIDTH    default operand/result width
//   ALU_CMD_LEN  width of the EXE command code
//   aluCmd_e     EXE command encodings (ADD..DIVU)
//   aluState_e   control FSM states of the ALU top
// ---------------------------------------------------------------------------
package alu_mc_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_CMD_LEN = 4;

    typedef enum logic [ALU_CMD_LEN-1:0] {
        CMD_ADD  = 4'd0,
        CMD_SUB  = 4'd1,
        CMD_AND  = 4'd2,
        CMD_OR   = 4'd3,
        CMD_NOR  = 4'd4,
        CMD_XOR  = 4'd5,
        CMD_SLT  = 4'd6,
        CMD_SLL  = 4'd7,
        CMD_SRL  = 4'd8,
        CMD_SRA  = 4'd9,
        CMD_MULU = 4'd10,
        CMD_DIVU = 4'd11
    } aluCmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } aluState_e;

endpackage

// File: rtl/alu_mc_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per
// cycle, WIDTH iterations per operation.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_abort        drop the operation in flight
//   i_start        load operands and begin (i_isDiv selects divide)
//   i_a, i_b       multiplicand/multiplier or dividend/divisor
//   o_done         high during the final iteration cycle
//   o_hi, o_lo     value the registers take at the end of this cycle; valid
//                  as the final product/remainder/quotient when o_done=1
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_abort,
    input  logic             i_start,
    input  logic             i_isDiv,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             r_run;
    logic             r_isDiv;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH:0]   w_divShift;
    logic [WIDTH:0]   w_divDiff;
    logic             w_divGe;
    logic [WIDTH-1:0] w_nextHi;
    logic [WIDTH-1:0] w_nextLo;

    // One iteration step. Multiply keeps {partial product, multiplier} in
    // {r_hi, r_lo} and shifts right; divide keeps {remainder, dividend/quotient}
    // and shifts left. A zero divisor always "fits", which naturally yields
    // an all-ones quotient and a remainder equal to the dividend.
    always_comb begin
        w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_divShift = {r_hi, r_lo[WIDTH-1]};
        w_divDiff  = w_divShift - {1'b0, r_b};
        w_divGe    = (w_divShift >= {1'b0, r_b});
        if (r_isDiv) begin
            w_nextHi = w_divGe ? w_divDiff[WIDTH-1:0] : w_divShift[WIDTH-1:0];
            w_nextLo = {r_lo[WIDTH-2:0], w_divGe};
        end else begin
            w_nextHi = w_mulSum[WIDTH:1];
            w_nextLo = {w_mulSum[0], r_lo[WIDTH-1:1]};
        end
    end

    assign o_done = r_run && (r_cnt == CW'(WIDTH - 1));
    assign o_hi   = w_nextHi;
    assign o_lo   = w_nextLo;

    // Operand load, iteration and counter; abort clears the run immediately.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run   <= 1'b0;
            r_isDiv <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
        end else if (i_abort) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_run   <= 1'b1;
            r_isDiv <= i_isDiv;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= i_a;
            r_b     <= i_b;
        end else if (r_run) begin
            r_hi <= w_nextHi;
            r_lo <= w_nextLo;
            if (o_done) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc
// Multi-cycle EXE-stage ALU: registered single-cycle ops plus iterative
// unsigned MULU/DIVU behind a valid/ready handshake.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_flush           abort in-flight/pending op (branch)
//   i_inValid         operands and command valid
//   o_inReady         unit accepts this cycle
//   i_cmd             operation code (aluCmd_e)
//   i_val1, i_val2    operands A, B
//   o_outValid        result valid, held until i_outReady
//   i_outReady        consumer takes result
//   o_resultLo/Hi     result / product low,high / quotient,remainder
//   o_zero, o_ovf     result_lo==0, signed overflow of ADD/SUB
//   o_busy            MUL/DIV iteration in progress
// ---------------------------------------------------------------------------
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int CMD_LEN = ALU_CMD_LEN
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_inValid,
    output logic               o_inReady,
    input  logic [CMD_LEN-1:0] i_cmd,
    input  logic [WIDTH-1:0]   i_val1,
    input  logic [WIDTH-1:0]   i_val2,
    output logic               o_outValid,
    input  logic               i_outReady,
    output logic [WIDTH-1:0]   o_resultLo,
    output logic [WIDTH-1:0]   o_resultHi,
    output logic               o_zero,
    output logic               o_ovf,
    output logic               o_busy
);

    localparam int SHW = $clog2(WIDTH);

    aluState_e        r_state;
    aluState_e        w_stateNext;
    logic             r_outValid;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_ovf;

    logic             w_accept;
    logic             w_isMul;
    logic             w_isDiv;
    logic             w_engDone;
    logic [WIDTH-1:0] w_engHi;
    logic [WIDTH-1:0] w_engLo;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_lo;
    logic             w_ovf;

    assign o_inReady = (r_state == ST_IDLE) && (!r_outValid || i_outReady) && !i_flush;
    assign w_accept  = i_inValid && o_inReady;
    assign w_isMul   = (i_cmd == CMD_MULU);
    assign w_isDiv   = (i_cmd == CMD_DIVU);

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_abort (i_flush),
        .i_start (w_accept && (w_isMul || w_isDiv)),
        .i_isDiv (w_isDiv),
        .i_a     (i_val1),
        .i_b     (i_val2),
        .o_done  (w_engDone),
        .o_hi    (w_engHi),
        .o_lo    (w_engLo)
    );

    // Single-cycle datapath; overflow is only meaningful for ADD/SUB.
    always_comb begin
        w_sum   = i_val1 + i_val2;
        w_diff  = i_val1 - i_val2;
        w_shamt = i_val2[SHW-1:0];
        w_lo    = '0;
        w_ovf   = 1'b0;
        case (i_cmd)
            CMD_ADD: begin
                w_lo  = w_sum;
                w_ovf = (i_val1[WIDTH-1] == i_val2[WIDTH-1]) && (w_sum[WIDTH-1] != i_val1[WIDTH-1]);
            end
            CMD_SUB: begin
                w_lo  = w_diff;
                w_ovf = (i_val1[WIDTH-1] != i_val2[WIDTH-1]) && (w_diff[WIDTH-1] != i_val1[WIDTH-1]);
            end
            CMD_AND: w_lo = i_val1 & i_val2;
            CMD_OR:  w_lo = i_val1 | i_val2;
            CMD_NOR: w_lo = ~(i_val1 | i_val2);
            CMD_XOR: w_lo = i_val1 ^ i_val2;
            CMD_SLT: w_lo = {{(WIDTH-1){1'b0}}, ($signed(i_val1) < $signed(i_val2))};
            CMD_SLL: w_lo = i_val1 << w_shamt;
            CMD_SRL: w_lo = i_val1 >> w_shamt;
            CMD_SRA: w_lo = WIDTH'($signed(i_val1) >>> w_shamt);
            default: w_lo = '0;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: flush wins over both a new accept and a completing iteration.
    always_comb begin
        w_stateNext = r_state;
        if (i_flush) begin
            w_stateNext = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_isMul) begin
                        w_stateNext = ST_MUL;
                    end else if (w_accept && w_isDiv) begin
                        w_stateNext = ST_DIV;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_engDone) begin
                        w_stateNext = ST_IDLE;
                    end
                end
                default: w_stateNext = ST_IDLE;
            endcase
        end
    end

    // Output registers. A consumed result is cleared unless a new one lands
    // in the same cycle, which gives back-to-back results without a bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_outValid <= 1'b0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_zero     <= 1'b1;
            r_ovf      <= 1'b0;
        end else if (i_flush) begin
            r_outValid <= 1'b0;
        end else begin
            if (r_outValid && i_outReady) begin
                r_outValid <= 1'b0;
            end
            if (w_accept && !w_isMul && !w_isDiv) begin
                r_outValid <= 1'b1;
                r_lo       <= w_lo;
                r_hi       <= '0;
                r_zero     <= (w_lo == '0);
                r_ovf      <= w_ovf;
            end else if ((r_state != ST_IDLE) && w_engDone) begin
                r_outValid <= 1'b1;
                r_lo       <= w_engLo;
                r_hi       <= w_engHi;
                r_zero     <= (w_engLo == '0);
                r_ovf      <= 1'b0;
            end
        end
    end

    assign o_outValid = r_outValid;
    assign o_resultLo = r_lo;
    assign o_resultHi = r_hi;
    assign o_zero     = r_zero;
    assign o_ovf      = r_ovf;
    assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc
// Directed self-checking bench for alu_mc (WIDTH=32).
// ---------------------------------------------------------------------------
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [3:0]   cmd = 4'd0;
    logic [W-1:0] val1 = '0;
    logic [W-1:0] val2 = '0;
    logic         outValid;
    logic         outReady = 1'b1;
    logic [W-1:0] resultLo;
    logic [W-1:0] resultHi;
    logic         zero;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int lat;
    int busyCycles;
    logic sawValid;

    alu_mc #(.WIDTH(W), .CMD_LEN(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_flush    (flush),
        .i_inValid  (inValid),
        .o_inReady  (inReady),
        .i_cmd      (cmd),
        .i_val1     (val1),
        .i_val2     (val2),
        .o_outValid (outValid),
        .i_outReady (outReady),
        .o_resultLo (resultLo),
        .o_resultHi (resultHi),
        .o_zero     (zero),
        .o_ovf      (ovf),
        .o_busy     (busy)
    );

    // 10-time-unit clock.
    initial forever #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation for a single edge, then drop in_valid.
    task automatic applyStimulus(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        cmd     = c;
        val1    = a;
        val2    = b;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
    endtask

    // Called in the cycle after a MULU/DIVU accept; returns the latency in
    // cycles from the accept cycle and the number of busy cycles seen.
    task automatic waitResult(output int latency, output int busyCnt);
        latency = 1;
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (outValid) break;
            if (busy) busyCnt++;
            tick();
            latency++;
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_outValid", outValid, 0);
        checkOutput("rst_lo", resultLo, 0);
        checkOutput("rst_hi", resultHi, 0);
        checkOutput("rst_zero", zero, 1);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_inReady", inReady, 1);

        // 1: ADD overflow
        applyStimulus(CMD_ADD, 32'h7FFF_FFFF, 32'h1);
        checkOutput("add_valid", outValid, 1);
        checkOutput("add_lo", resultLo, 32'h8000_0000);
        checkOutput("add_hi", resultHi, 0);
        checkOutput("add_ovf", ovf, 1);
        checkOutput("add_zero", zero, 0);
        tick();
        checkOutput("add_consumed", outValid, 0);

        // 2: SUB then XOR back-to-back
        cmd = CMD_SUB; val1 = 32'd5; val2 = 32'd5; inValid = 1'b1;
        tick();
        cmd = CMD_XOR; val1 = 32'h0000_F0F0; val2 = 32'h0000_0FF0;
        #1;
        checkOutput("sub_valid", outValid, 1);
        checkOutput("sub_lo", resultLo, 0);
        checkOutput("sub_zero", zero, 1);
        checkOutput("sub_ovf", ovf, 0);
        checkOutput("b2b_inReady", inReady, 1);
        tick();
        inValid = 1'b0;
        checkOutput("xor_valid", outValid, 1);
        checkOutput("xor_lo", resultLo, 32'h0000_FF00);
        checkOutput("xor_zero", zero, 0);
        tick();
        checkOutput("xor_consumed", outValid, 0);

        // SLT signed and SLL
        applyStimulus(CMD_SLT, 32'hFFFF_FFFF, 32'h1);
        checkOutput("slt_lo", resultLo, 1);
        applyStimulus(CMD_SLL, 32'h0000_0003, 32'h0000_0024);
        checkOutput("sll_lo", resultLo, 32'h0000_0030);
        applyStimulus(4'd13, 32'h1234_5678, 32'h1);
        checkOutput("undef_valid", outValid, 1);
        checkOutput("undef_lo", resultLo, 0);
        tick();

        // 3: MULU max*max
        applyStimulus(CMD_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("mul_busy", busy, 1);
        checkOutput("mul_inReady", inReady, 0);
        waitResult(lat, busyCycles);
        checkOutput("mul_latency", lat, 33);
        checkOutput("mul_busyCycles", busyCycles, 32);
        checkOutput("mul_valid", outValid, 1);
        checkOutput("mul_hi", resultHi, 32'hFFFF_FFFE);
        checkOutput("mul_lo", resultLo, 32'h0000_0001);
        checkOutput("mul_idle", busy, 0);
        tick();

        // 4: DIVU 100/7 and 9/0
        applyStimulus(CMD_DIVU, 32'd100, 32'd7);
        waitResult(lat, busyCycles);
        checkOutput("div_latency", lat, 33);
        checkOutput("div_lo", resultLo, 32'd14);
        checkOutput("div_hi", resultHi, 32'd2);
        tick();
        applyStimulus(CMD_DIVU, 32'd9, 32'd0);
        waitResult(lat, busyCycles);
        checkOutput("div0_latency", lat, 33);
        checkOutput("div0_lo", resultLo, 32'hFFFF_FFFF);
        checkOutput("div0_hi", resultHi, 32'd9);
        tick();

        // 5: flush during MULU
        applyStimulus(CMD_MULU, 32'd1000, 32'd1000);
        repeat (9) tick();
        flush = 1'b1;
        #1;
        checkOutput("flush_inReady", inReady, 0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("flush_busy", busy, 0);
        checkOutput("flush_outValid", outValid, 0);
        checkOutput("flush_inReadyAfter", inReady, 1);
        sawValid = 1'b0;
        repeat (40) begin
            tick();
            if (outValid) sawValid = 1'b1;
        end
        checkOutput("flush_noResult", sawValid, 0);
        applyStimulus(CMD_ADD, 32'd2, 32'd3);
        checkOutput("postflush_lo", resultLo, 32'd5);
        tick();

        // 6: output hold under back-pressure
        outReady = 1'b0;
        applyStimulus(CMD_SRA, 32'h8000_0000, 32'd4);
        cmd = CMD_ADD; val1 = 32'd1; val2 = 32'd1; inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("hold_valid", outValid, 1);
            checkOutput("hold_lo", resultLo, 32'hF800_0000);
            checkOutput("hold_inReady", inReady, 0);
            tick();
        end
        checkOutput("hold_loEnd", resultLo, 32'hF800_0000);
        inValid = 1'b0;
        outReady = 1'b1;
        tick();
        checkOutput("hold_released", outValid, 0);

        // Reset in the middle of a DIVU
        applyStimulus(CMD_DIVU, 32'd100, 32'd7);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_outValid", outValid, 0);
        checkOutput("midrst_lo", resultLo, 0);
        checkOutput("midrst_hi", resultHi, 0);
        checkOutput("midrst_zero", zero, 1);
        checkOutput("midrst_ovf", ovf, 0);
        checkOutput("midrst_busy", busy, 0);
        sawValid = 1'b0;
        repeat (40) begin
            tick();
            if (outValid) sawValid = 1'b1;
        end
        checkOutput("midrst_noResult", sawValid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
